// File: rtl/slv_resp_pkg.sv
// Shared types and constants for the slv_mem_resp bus responder, plus the 39-bit SEC-DED
// Hamming helpers used by the optional read scrub path.
package slv_resp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StResp,
      StErr1,
      StErr2
   } state_e;

   localparam logic [2:0]  SZ_WORD     = 3'b010;
   localparam int unsigned MOD_ACT_BIT = 1;
   localparam int unsigned DW          = 39;
   localparam int unsigned WCNT_W      = 4;

   typedef struct packed {
      logic          sec;
      logic          ded;
      logic [DW-1:0] fixed;
   } ecc_res_t;

   // Bit 0 is overall parity; bits 1..38 are Hamming positions with check bits at powers of two.
   function automatic logic [DW-1:0] ecc_encode(input logic [31:0] data);
      logic [DW-1:0] code;
      logic [5:0]    syn;
      int unsigned   j;
      code = '0;
      syn  = '0;
      j    = 0;
      for (int unsigned p = 1; p < DW; p++) begin
         if ((p & (p - 1)) != 0) begin
            code[p] = data[j];
            j++;
         end
      end
      for (int unsigned p = 1; p < DW; p++) begin
         if (code[p]) syn ^= 6'(p);
      end
      for (int unsigned k = 0; k < 6; k++) begin
         code[1 << k] = syn[k];
      end
      code[0] = ^code[DW-1:1];
      return code;
   endfunction

   // A syndrome of zero with odd parity points at bit 0, so one flip handles both cases.
   function automatic ecc_res_t ecc_decode(input logic [DW-1:0] code);
      ecc_res_t   res;
      logic [5:0] syn;
      logic       odd;
      syn = '0;
      for (int unsigned p = 1; p < DW; p++) begin
         if (code[p]) syn ^= 6'(p);
      end
      odd       = ^code;
      res.fixed = code;
      res.sec   = 1'b0;
      res.ded   = 1'b0;
      if (odd) begin
         if (syn < 6'(DW)) begin
            res.sec        = 1'b1;
            res.fixed[syn] = ~code[syn];
         end else begin
            res.ded = 1'b1;
         end
      end else if (syn != '0) begin
         res.ded = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/slv_mem_array.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous read port,
// all words cleared while the synchronous active-low reset is asserted.
module slv_mem_array
   import slv_resp_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/slv_mem_resp.sv
// Core-B Lite bus responder fronting a Hamming-coded word memory with WAIT_CYC wait states.
// Define SLV_ECC_SCRUB_EN to correct single-bit read errors (with write-back) and fault double ones.
module slv_mem_resp
   import slv_resp_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned WAIT_CYC  = 0
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic          SsSEL,
   input  logic          MxWT,
   input  logic [2:0]    MxSZ,
   input  logic [3:0]    MxRB,
   input  logic [2:0]    MxMOD,
   input  logic          MxLK,
   input  logic [31:0]   MxADDR,
   input  logic [DW-1:0] MxWDT,
   output logic          MsRDY,
   output logic          MsERR,
   output logic [DW-1:0] MsRDT
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [WCNT_W-1:0] WCNT_LAST = (WAIT_CYC == 0) ? '0 : WCNT_W'(WAIT_CYC - 1);

   state_e            state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              wt_q, wt_d;
   logic [AW-1:0]     idx_q, idx_d;
   logic              accept, legal, rd_err, scrub, mem_we;
   logic [DW-1:0]     mem_wdata, mem_rdata, rd_word;
   logic              unused_in;

   assign unused_in = ^{MxRB, MxLK, MxMOD[2], MxMOD[0]};

   // BASE_ADDR is DEPTH*4 aligned, so range membership is an upper-bit match.
   assign legal  = (MxSZ == SZ_WORD) && (MxADDR[1:0] == 2'b00) &&
                   (MxADDR[31:AW+2] == BASE_ADDR[31:AW+2]);
   assign accept = SsSEL & MxMOD[MOD_ACT_BIT] & MsRDY;

`ifdef SLV_ECC_SCRUB_EN
   ecc_res_t ecc;
   assign ecc     = ecc_decode(mem_rdata);
   assign rd_word = ecc.fixed;
   assign rd_err  = (state_q == StResp) && !wt_q && ecc.ded;
   assign scrub   = !wt_q && ecc.sec;
`else
   assign rd_word = mem_rdata;
   assign rd_err  = 1'b0;
   assign scrub   = 1'b0;
`endif

   slv_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk_i   (CLK),
      .rst_ni  (nRST),
      .we_i    (mem_we),
      .waddr_i (idx_q),
      .wdata_i (mem_wdata),
      .raddr_i (idx_q),
      .rdata_o (mem_rdata)
   );

   // An uncorrectable read turns the RESP cycle into ERR1.
   always_comb begin
      MsRDY = 1'b0;
      MsERR = 1'b0;
      MsRDT = '0;
      unique case (state_q)
         StIdle: MsRDY = 1'b1;
         StWait: ;
         StResp: begin
            MsRDY = !rd_err;
            MsERR = rd_err;
            if (!wt_q && !rd_err) MsRDT = rd_word;
         end
         StErr1: MsERR = 1'b1;
         StErr2: begin
            MsRDY = 1'b1;
            MsERR = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      wt_d      = wt_q;
      idx_d     = idx_q;
      mem_we    = 1'b0;
      mem_wdata = MxWDT;
      unique case (state_q)
         StWait: begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WCNT_LAST) state_d = StResp;
         end
         StResp: begin
            if (rd_err) begin
               state_d = StErr2;
            end else begin
               state_d = StIdle;
               if (wt_q) begin
                  mem_we = 1'b1;
               end else if (scrub) begin
                  mem_we    = 1'b1;
                  mem_wdata = rd_word;
               end
            end
         end
         StErr1: state_d = StErr2;
         StErr2: state_d = StIdle;
         default: ;
      endcase
      // Accept overrides the return to idle so back-to-back beats have no bubble.
      if (accept) begin
         wt_d   = MxWT;
         idx_d  = MxADDR[AW+1:2];
         wcnt_d = '0;
         if (!legal) begin
            state_d = StErr1;
         end else if (WAIT_CYC == 0) begin
            state_d = StResp;
         end else begin
            state_d = StWait;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= StIdle;
         wcnt_q  <= '0;
         wt_q    <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         wt_q    <= wt_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: tb/tb_slv_mem_resp.sv
// Bench for slv_mem_resp: two instances (zero and three wait states) driven by directed and
// random transfers, checked cycle by cycle against an array-based reference model.
module tb_slv_mem_resp;

   localparam int unsigned    DEP0  = 256;
   localparam int unsigned    DEP1  = 16;
   localparam logic [31:0]    BASE0 = 32'h0000_0000;
   localparam logic [31:0]    BASE1 = 32'h0000_0400;
   localparam int unsigned    WC0   = 0;
   localparam int unsigned    WC1   = 3;

   logic        clk = 1'b0;
   logic        nrst;
   logic        sel  [2];
   logic        wt   [2];
   logic [2:0]  sz   [2];
   logic [3:0]  rb   [2];
   logic [2:0]  mode [2];
   logic        lk   [2];
   logic [31:0] addr [2];
   logic [38:0] wdt  [2];
   logic        rdy0, rdy1, err0, err1;
   logic [38:0] rdt0, rdt1;
   logic [38:0] mdl [2][256];
   int          vecs = 0;
   int          errs = 0;

   always #5 clk = ~clk;

   slv_mem_resp #(.DEPTH(DEP0), .BASE_ADDR(BASE0), .WAIT_CYC(WC0)) u_dut0 (
      .CLK(clk), .nRST(nrst), .SsSEL(sel[0]), .MxWT(wt[0]), .MxSZ(sz[0]), .MxRB(rb[0]),
      .MxMOD(mode[0]), .MxLK(lk[0]), .MxADDR(addr[0]), .MxWDT(wdt[0]),
      .MsRDY(rdy0), .MsERR(err0), .MsRDT(rdt0)
   );

   slv_mem_resp #(.DEPTH(DEP1), .BASE_ADDR(BASE1), .WAIT_CYC(WC1)) u_dut1 (
      .CLK(clk), .nRST(nrst), .SsSEL(sel[1]), .MxWT(wt[1]), .MxSZ(sz[1]), .MxRB(rb[1]),
      .MxMOD(mode[1]), .MxLK(lk[1]), .MxADDR(addr[1]), .MxWDT(wdt[1]),
      .MsRDY(rdy1), .MsERR(err1), .MsRDT(rdt1)
   );

   // Code: parity bits at positions 1,2,4..32 zero the XOR of set positions; bit 0 makes weight even.
   function automatic logic [38:0] enc(input logic [31:0] d);
      logic [38:0] c;
      int          j;
      int          s;
      c = '0;
      j = 0;
      s = 0;
      for (int p = 1; p < 39; p++) begin
         if (!$onehot(p)) begin
            c[p] = d[j];
            if (d[j]) s ^= p;
            j++;
         end
      end
      for (int k = 0; k < 6; k++) c[1 << k] = s[k];
      c[0] = ^c;
      return c;
   endfunction

   function automatic logic is_code(input logic [38:0] c);
      logic [31:0] d;
      int          j;
      d = '0;
      j = 0;
      for (int p = 1; p < 39; p++) begin
         if (!$onehot(p)) begin
            d[j] = c[p];
            j++;
         end
      end
      return enc(d) == c;
   endfunction

   // kind: 0 clean, 1 one flip away from a codeword, 2 uncorrectable
   task automatic classify(input logic [38:0] c, output int kind, output logic [38:0] fixed);
      kind  = 2;
      fixed = c;
      if (is_code(c)) begin
         kind = 0;
      end else begin
         for (int i = 0; i < 39; i++) begin
            if (kind == 2 && is_code(c ^ (39'(1) << i))) begin
               kind  = 1;
               fixed = c ^ (39'(1) << i);
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle(input int d, input string tag, input logic er, input logic ee,
                              input logic [38:0] ed);
      logic        r, e;
      logic [38:0] t;
      if (d == 0) begin
         r = rdy0; e = err0; t = rdt0;
      end else begin
         r = rdy1; e = err1; t = rdt1;
      end
      chk({tag, "/rdy"}, {38'b0, r}, {38'b0, er});
      chk({tag, "/err"}, {38'b0, e}, {38'b0, ee});
      chk({tag, "/rdt"}, t, ed);
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) for (int i = 0; i < 256; i++) mdl[d][i] = '0;
   endtask

   // Entered #1 after an edge with the DUT ready; returns in the completing cycle.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [2:0] s,
                       input logic [38:0] wd, input string tag);
      longint unsigned lo, hi;
      logic            legal, ded, er, ee;
      logic [38:0]     rexp, ed;
      int              idx, lat, wc, kind;
      lo    = (d == 0) ? BASE0 : BASE1;
      hi    = lo + 4 * ((d == 0) ? DEP0 : DEP1);
      wc    = (d == 0) ? WC0 : WC1;
      legal = (s == 3'b010) && (a[1:0] == 2'b00) && (a >= lo) && (a < hi);
      idx   = legal ? int'((a - lo) >> 2) : 0;
      rexp  = mdl[d][idx];
      ded   = 1'b0;
      kind  = 0;
`ifdef SLV_ECC_SCRUB_EN
      if (legal && !w) begin
         classify(mdl[d][idx], kind, rexp);
         ded = (kind == 2);
      end
`endif
      sel[d]  = 1'b1;
      mode[d] = {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))};
      wt[d]   = w;
      addr[d] = a;
      sz[d]   = s;
      rb[d]   = 4'($urandom_range(0, 15));
      lk[d]   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      sel[d]  = 1'b0;
      mode[d] = 3'b000;
      wt[d]   = ~w;
      addr[d] = $urandom;
      sz[d]   = 3'($urandom_range(0, 7));
      wdt[d]  = wd;
      lat = !legal ? 2 : (ded ? wc + 2 : wc + 1);
      for (int k = 1; k <= lat; k++) begin
         if (!legal) begin
            er = (k == 2); ee = 1'b1; ed = '0;
         end else if (k <= wc) begin
            er = 1'b0; ee = 1'b0; ed = '0;
         end else if (ded) begin
            er = (k == wc + 2); ee = 1'b1; ed = '0;
         end else begin
            er = 1'b1; ee = 1'b0; ed = w ? 39'h0 : rexp;
         end
         check_cycle(d, tag, er, ee, ed);
         if (k < lat) begin
            @(posedge clk); #1;
         end
      end
      if (legal && w) mdl[d][idx] = wd;
      else if (legal && !ded) mdl[d][idx] = rexp;
   endtask

   task automatic idle(input int n, input logic s, input logic [2:0] m, input string tag);
      for (int i = 0; i < n; i++) begin
         sel[0] = s; sel[1] = s; mode[0] = m; mode[1] = m;
         @(posedge clk); #1;
         check_cycle(0, tag, 1'b1, 1'b0, 39'h0);
         check_cycle(1, tag, 1'b1, 1'b0, 39'h0);
      end
      sel[0] = 1'b0; sel[1] = 1'b0; mode[0] = 3'b000; mode[1] = 3'b000;
   endtask

   initial begin
      int              r, f, widx, dep;
      longint unsigned base;
      logic [31:0]     a;
      logic [2:0]      s;
      logic            w;
      logic [38:0]     wd;

      nrst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         sel[d] = 1'b0; wt[d] = 1'b0; sz[d] = 3'b010; rb[d] = '0;
         mode[d] = 3'b000; lk[d] = 1'b0; addr[d] = '0; wdt[d] = '0;
      end
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      check_cycle(0, "reset0", 1'b1, 1'b0, 39'h0);
      check_cycle(1, "reset1", 1'b1, 1'b0, 39'h0);
      nrst = 1'b1;
      idle(2, 1'b0, 3'b000, "post_reset");

      xfer(0, 1'b1, 32'h10, 3'b010, enc(32'hA5A5_5A5A), "w0_wr");
      xfer(0, 1'b0, 32'h10, 3'b010, '0, "w0_rd");
      idle(1, 1'b0, 3'b000, "gap");

      xfer(1, 1'b1, 32'h404, 3'b010, enc(32'h1234_5678), "w3_wr");
      xfer(1, 1'b0, 32'h404, 3'b010, '0, "w3_rd_a");
      xfer(1, 1'b0, 32'h404, 3'b010, '0, "w3_rd_b");
      idle(1, 1'b0, 3'b000, "gap");

      xfer(1, 1'b1, 32'h400, 3'b010, enc(32'hCAFE_F00D), "err_setup");
      xfer(1, 1'b1, 32'h400, 3'b000, enc(32'h0), "err_size");
      xfer(1, 1'b1, 32'h402, 3'b010, enc(32'h1), "err_misalign");
      xfer(1, 1'b1, 32'h440, 3'b010, enc(32'h2), "err_above");
      xfer(1, 1'b1, 32'h3FC, 3'b010, enc(32'h3), "err_below");
      xfer(1, 1'b0, 32'h400, 3'b010, '0, "err_rdback");
      xfer(0, 1'b1, 32'h2, 3'b010, enc(32'h4), "err0_misalign");
      xfer(0, 1'b1, 32'h400, 3'b010, enc(32'h5), "err0_above");
      xfer(0, 1'b0, 32'h10, 3'b010, '0, "err0_rdback");

      xfer(1, 1'b1, 32'h408, 3'b010, enc(32'h1111_2222), "rst_setup");
      idle(1, 1'b0, 3'b000, "gap");
      sel[1] = 1'b1; mode[1] = 3'b010; wt[1] = 1'b1; addr[1] = 32'h408; sz[1] = 3'b010;
      @(posedge clk); #1;
      sel[1] = 1'b0; mode[1] = 3'b000; wdt[1] = enc(32'h5555_AAAA);
      check_cycle(1, "rst_wait", 1'b0, 1'b0, 39'h0);
      @(posedge clk); #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      check_cycle(1, "rst_abort1", 1'b1, 1'b0, 39'h0);
      check_cycle(0, "rst_abort0", 1'b1, 1'b0, 39'h0);
      nrst = 1'b1;
      clear_model();
      xfer(1, 1'b0, 32'h408, 3'b010, '0, "rst_rd408");
      xfer(1, 1'b0, 32'h404, 3'b010, '0, "rst_rd404");
      xfer(0, 1'b0, 32'h10, 3'b010, '0, "rst_rd010");

      idle(10, 1'b1, 3'b000, "inactive");
      idle(3, 1'b1, 3'b101, "inactive_b");

`ifdef SLV_ECC_SCRUB_EN
      xfer(0, 1'b1, 32'h14, 3'b010, enc(32'h0BAD_F00D) ^ 39'h80, "ecc_w1");
      xfer(0, 1'b0, 32'h14, 3'b010, '0, "ecc_sec");
      xfer(0, 1'b0, 32'h14, 3'b010, '0, "ecc_fixed");
      chk("ecc_model", mdl[0][5], enc(32'h0BAD_F00D));
      xfer(0, 1'b1, 32'h14, 3'b010, enc(32'h0BAD_F00D) ^ 39'h180, "ecc_w2");
      xfer(0, 1'b0, 32'h14, 3'b010, '0, "ecc_ded");
      xfer(1, 1'b1, 32'h414, 3'b010, enc(32'h7777_0000) ^ 39'h1, "ecc1_w");
      xfer(1, 1'b0, 32'h414, 3'b010, '0, "ecc1_sec");
      xfer(1, 1'b0, 32'h414, 3'b010, '0, "ecc1_fixed");
`endif

      for (int d = 0; d < 2; d++) begin
         base = (d == 0) ? BASE0 : BASE1;
         dep  = (d == 0) ? DEP0 : DEP1;
         for (int n = 0; n < 120; n++) begin
            r    = $urandom_range(0, 11);
            f    = $urandom_range(0, 9);
            w    = 1'($urandom_range(0, 1));
            widx = ($urandom_range(0, 4) == 0) ? $urandom_range(0, dep - 1) : $urandom_range(0, 7);
            a    = 32'(base + 4 * widx);
            s    = 3'b010;
            if (r == 0) s = 3'($urandom_range(0, 7));
            else if (r == 1) a[1:0] = 2'($urandom_range(1, 3));
            else if (r == 2) a = 32'(base + 4 * dep + 4 * $urandom_range(0, 7));
            else if (r == 3 && d == 1) a = 32'(base - 4 * $urandom_range(1, 4));
            wd = enc($urandom);
            if (f == 0) wd ^= 39'(1) << $urandom_range(0, 38);
            if (f == 1) wd ^= (39'(1) << $urandom_range(0, 38)) ^ (39'(1) << $urandom_range(0, 38));
            xfer(d, w, a, s, wd, (d == 0) ? "rand0" : "rand1");
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'b0, 3'b000, "rand_gap");
         end
      end

      idle(2, 1'b0, 3'b000, "final");
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
